ahb_bus_arbiter: RTL and testbench
==================================

Name: ahb_bus_arbiter

Overview:
- AHB arbiter directly downstream of the CPU fetch and data-memory master wrappers.
- Consumes each master's HBUSREQ/HLOCK and returns a one-hot HGRANT.
- Drives HMASTER, HMASTER_D and HMASTLOCK to the address/data multiplexers and slaves.
- Rotating priority with lock honouring; a hold-limit counter prevents an unlocked master from starving others.

Parameters:
NUM_MASTERS, 2, number of requesting masters (index 0 = fetch wrapper, 1 = data wrapper); range 2..8
MAX_HOLD, 16, max consecutive cycles an unlocked owner keeps the grant while another master is requesting; 0 disables preemption
MW, $clog2(NUM_MASTERS), width of master index outputs (derived, not overridden)

Ports:
HCLK  input  1  bus clock, all state on rising edge
rst  input  1  synchronous, active-high reset
HBUSREQ  input  NUM_MASTERS  per-master bus request
HLOCK  input  NUM_MASTERS  per-master locked-transfer request
HREADY  input  1  slave ready; bus ownership changes only on cycles with HREADY=1
HGRANT  output  NUM_MASTERS  one-hot (or all-zero) registered grant
HMASTER  output  MW  address-phase owner index
HMASTER_D  output  MW  data-phase owner index (HMASTER delayed by one HREADY=1 cycle)
HMASTLOCK  output  1  current address-phase transfer is locked
bus_busy  output  1  high whenever any HGRANT bit is set

Behaviour:
- Reset (rst=1 at clock edge): HGRANT=0, HMASTER=0, HMASTER_D=0, HMASTLOCK=0, state=IDLE, hold_cnt=0, rr_ptr=NUM_MASTERS-1 (so master 0 wins first).
- No bus parking: HGRANT stays all-zero in IDLE, because the master wrappers start a transfer on HGRANT alone.
- Winner selection: first requester with HBUSREQ[i]=1, searching from rr_ptr+1 upward modulo NUM_MASTERS.
- State IDLE:
  - Any HBUSREQ=1 with HREADY=1 → HGRANT[winner]=1, HMASTER=winner, rr_ptr=winner, hold_cnt=0, go to OWNED. Request-to-grant latency is exactly 1 cycle.
  - HREADY=0 → stay in IDLE, outputs unchanged.
- State OWNED, owner o, active = HBUSREQ[o] | HLOCK[o]:
  - HLOCK[o]=1: keep grant unconditionally; hold_cnt held at 0; other requests ignored.
  - active, HLOCK[o]=0, another master requesting, hold_cnt < MAX_HOLD-1: keep grant, hold_cnt+1.
  - active, HLOCK[o]=0, another master requesting, hold_cnt reaches MAX_HOLD-1 with HREADY=1: preempt to the next winner (search excludes o), same-cycle handover, hold_cnt=0.
  - active, no other requester: hold_cnt held at 0.
  - not active and HREADY=1: hand over directly to the next winner if any request exists (no idle bubble), else go to IDLE with HGRANT=0.
  - not active and HREADY=0: keep the grant until a cycle with HREADY=1.
- HMASTLOCK: registered on every HREADY=1 cycle as HLOCK[new address-phase owner]; 0 when no owner.
- HMASTER_D: loads HMASTER on every HREADY=1 cycle; holds while HREADY=0.
- Simultaneous events:
  - Owner drops its request in the same cycle as a new request arrives: handover in that cycle.
  - Lock and preemption in the same cycle: lock wins.
  - A master whose request and lock both drop with HREADY=0 keeps its grant until HREADY=1.
- Reset asserted mid-ownership: all outputs return to reset values on that edge; the grant is lost immediately.
- Invariants (assertion-checked): HGRANT is $onehot0; HGRANT only changes on cycles where HREADY=1 or rst=1.

Test Plan:
- Reset, then HBUSREQ=2'b01 for 1 cycle with HLOCK=2'b01 held 3 cycles, HREADY=1 → HGRANT=01 one cycle after request, held 3 cycles, then 00; HMASTLOCK=1 while locked.
- HBUSREQ=2'b11 continuous from reset, MAX_HOLD=4, HLOCK=0 → grants alternate 01 for 4 cycles, 10 for 4 cycles, repeating; HMASTER_D trails HMASTER by 1 cycle.
- Master 0 locked (HLOCK[0]=1 for 20 cycles), master 1 requesting, MAX_HOLD=4 → HGRANT=01 for all 20 cycles, 10 on the cycle after HLOCK[0] drops.
- Owner releases while HREADY=0 for 3 cycles → HGRANT, HMASTER and HMASTER_D unchanged until HREADY=1, then handover or IDLE.
- Master 1 holds the grant; its request drops and master 0 requests in the same cycle → HGRANT goes 10→01 with no all-zero cycle.
- rst pulsed while HGRANT=10 and HMASTLOCK=1 → next edge: HGRANT=00, HMASTER=0, HMASTLOCK=0; the next request from both masters is won by master 0.

Source files
------------

// File: rtl/ahb_bus_arbiter.sv
// AHB bus arbiter: rotating priority, honours HLOCK, and limits how long an
// unlocked owner may keep the bus while another master is waiting.
// Ownership moves only on HREADY=1 cycles. HGRANT is registered and one-hot.
module ahb_bus_arbiter #(
   parameter int NUM_MASTERS = 2,
   parameter int MAX_HOLD    = 16,
   localparam int MW         = $clog2(NUM_MASTERS)
) (
   input  logic                   HCLK,
   input  logic                   rst,
   input  logic [NUM_MASTERS-1:0] HBUSREQ,
   input  logic [NUM_MASTERS-1:0] HLOCK,
   input  logic                   HREADY,
   output logic [NUM_MASTERS-1:0] HGRANT,
   output logic [MW-1:0]          HMASTER,
   output logic [MW-1:0]          HMASTER_D,
   output logic                   HMASTLOCK,
   output logic                   bus_busy
);

   localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
   localparam logic [HW-1:0] HOLD_LAST = (MAX_HOLD > 0) ? HW'(MAX_HOLD - 1) : '0;

   typedef enum logic {IDLE, OWNED} state_t;

   state_t          state, state_n;
   logic [MW-1:0]   owner_n;
   logic [MW-1:0]   rr_ptr, rr_n;
   logic [HW-1:0]   hold_cnt, hold_n;
   logic [MW:0]     win_all, win_oth;
   logic [NUM_MASTERS-1:0] others;
   logic            active;

   // First requester searching upward from ptr+1 (mod N); MSB flags a hit.
   // The loop runs from the far end so the nearest candidate overwrites.
   function automatic logic [MW:0] pick(input logic [NUM_MASTERS-1:0] req,
                                        input logic [MW-1:0] ptr);
      logic [MW:0] r;
      int          idx;
      r = '0;
      for (int k = NUM_MASTERS; k >= 1; k--) begin
         idx = (int'(ptr) + k) % NUM_MASTERS;
         if (req[idx]) r = {1'b1, MW'(idx)};
      end
      return r;
   endfunction

   assign others   = HBUSREQ & ~(NUM_MASTERS'(1) << HMASTER);
   assign active   = HBUSREQ[HMASTER] | HLOCK[HMASTER];
   assign win_all  = pick(HBUSREQ, rr_ptr);
   assign win_oth  = pick(others, rr_ptr);
   assign bus_busy = |HGRANT;

   // Next owner / hold counter / rotation pointer.
   always_comb begin
      state_n = state;
      owner_n = HMASTER;
      rr_n    = rr_ptr;
      hold_n  = hold_cnt;
      case (state)
         IDLE: begin
            if (HREADY && win_all[MW]) begin
               state_n = OWNED;
               owner_n = win_all[MW-1:0];
               rr_n    = win_all[MW-1:0];
               hold_n  = '0;
            end
         end
         OWNED: begin
            if (HLOCK[HMASTER]) begin
               hold_n = '0;
            end else if (active) begin
               if ((|others) && (MAX_HOLD != 0)) begin
                  if (hold_cnt >= HOLD_LAST) begin
                     // Time is up: preempt, but only on a ready cycle.
                     if (HREADY) begin
                        owner_n = win_oth[MW-1:0];
                        rr_n    = win_oth[MW-1:0];
                        hold_n  = '0;
                     end
                  end else begin
                     hold_n = hold_cnt + HW'(1);
                  end
               end else begin
                  hold_n = '0;
               end
            end else if (HREADY) begin
               // Owner released: hand over directly, or fall back to IDLE.
               hold_n = '0;
               if (win_all[MW]) begin
                  owner_n = win_all[MW-1:0];
                  rr_n    = win_all[MW-1:0];
               end else begin
                  state_n = IDLE;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // State and registered bus outputs; HMASTLOCK/HMASTER_D advance on HREADY.
   always_ff @(posedge HCLK) begin
      if (rst) begin
         state     <= IDLE;
         rr_ptr    <= MW'(NUM_MASTERS - 1);
         hold_cnt  <= '0;
         HGRANT    <= '0;
         HMASTER   <= '0;
         HMASTER_D <= '0;
         HMASTLOCK <= 1'b0;
      end else begin
         state    <= state_n;
         rr_ptr   <= rr_n;
         hold_cnt <= hold_n;
         HMASTER  <= owner_n;
         HGRANT   <= (state_n == OWNED) ? (NUM_MASTERS'(1) << owner_n) : '0;
         if (HREADY) begin
            HMASTER_D <= HMASTER;
            HMASTLOCK <= (state_n == OWNED) ? HLOCK[owner_n] : 1'b0;
         end
      end
   end

   a_onehot: assert property (@(posedge HCLK) $onehot0(HGRANT));
   a_stable: assert property (@(posedge HCLK)
                (!$past(HREADY) && !$past(rst)) |-> $stable(HGRANT));

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Directed + randomized bench for ahb_bus_arbiter with a behavioural model
// that tracks the owner as an integer (-1 = bus free).
module tb_ahb_bus_arbiter;

   localparam int N  = 2;
   localparam int MH = 4;

   logic         HCLK = 1'b0;
   logic         rst = 1'b1;
   logic         HREADY = 1'b1;
   logic [N-1:0] HBUSREQ = '0;
   logic [N-1:0] HLOCK = '0;
   logic [N-1:0] HGRANT;
   logic [0:0]   HMASTER, HMASTER_D;
   logic         HMASTLOCK, bus_busy;

   int ncmp = 0;
   int nfail = 0;

   // reference model state
   int m_own = -1;
   int m_hm  = 0;
   int m_hmd = 0;
   int m_cnt = 0;
   int m_ptr = N - 1;
   bit m_lk  = 1'b0;

   ahb_bus_arbiter #(.NUM_MASTERS(N), .MAX_HOLD(MH)) dut (
      .HCLK(HCLK), .rst(rst), .HBUSREQ(HBUSREQ), .HLOCK(HLOCK), .HREADY(HREADY),
      .HGRANT(HGRANT), .HMASTER(HMASTER), .HMASTER_D(HMASTER_D),
      .HMASTLOCK(HMASTLOCK), .bus_busy(bus_busy)
   );

   always #5 HCLK = ~HCLK;

   // first requester after 'from' in rotating order, never 'skip'; -1 if none
   function automatic int search(input logic [N-1:0] req, input int from, input int skip);
      for (int k = 1; k <= N; k++) begin
         int i;
         i = (from + k) % N;
         if (i != skip && req[i]) return i;
      end
      return -1;
   endfunction

   task automatic model(input logic [N-1:0] br, input logic [N-1:0] lk,
                        input logic rdy, input logic r);
      int nxt;
      if (r) begin
         m_own = -1; m_hm = 0; m_hmd = 0; m_cnt = 0; m_ptr = N - 1; m_lk = 1'b0;
      end else begin
         nxt = m_own;
         if (m_own < 0) begin
            if (rdy) begin
               nxt = search(br, m_ptr, -1);
               m_cnt = 0;
            end
         end else if (lk[m_own]) begin
            m_cnt = 0;
         end else if (br[m_own]) begin
            if (search(br, m_own, m_own) >= 0 && MH > 0) begin
               if (m_cnt == MH - 1) begin
                  if (rdy) begin
                     nxt = search(br, m_own, m_own);
                     m_cnt = 0;
                  end
               end else begin
                  m_cnt++;
               end
            end else begin
               m_cnt = 0;
            end
         end else if (rdy) begin
            nxt = search(br, m_own, -1);
            m_cnt = 0;
         end
         if (rdy) begin
            m_hmd = m_hm;
            m_lk  = (nxt >= 0) ? lk[nxt] : 1'b0;
         end
         if (nxt >= 0) begin
            m_hm  = nxt;
            m_ptr = nxt;
         end
         m_own = nxt;
      end
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic [N-1:0] br, input logic [N-1:0] lk,
                       input logic rdy, input logic r);
      HBUSREQ = br; HLOCK = lk; HREADY = rdy; rst = r;
      @(posedge HCLK);
      model(br, lk, rdy, r);
      #1;
      chk("HGRANT",    8'(HGRANT),    (m_own >= 0) ? (8'd1 << m_own) : 8'd0);
      chk("HMASTER",   8'(HMASTER),   8'(m_hm));
      chk("HMASTER_D", 8'(HMASTER_D), 8'(m_hmd));
      chk("HMASTLOCK", 8'(HMASTLOCK), 8'(m_lk));
      chk("bus_busy",  8'(bus_busy),  8'(m_own >= 0));
   endtask

   initial begin
      logic [N-1:0] br, lk;
      // reset
      step(2'b00, 2'b00, 1'b1, 1'b1);
      step(2'b00, 2'b00, 1'b1, 1'b1);
      chk("rst_gnt", 8'(HGRANT), 8'h00);

      // single locked request: grant next cycle, held 3 cycles, then released
      step(2'b01, 2'b01, 1'b1, 1'b0);
      chk("tp1_gnt", 8'(HGRANT), 8'h01);
      chk("tp1_lock", 8'(HMASTLOCK), 8'h01);
      step(2'b00, 2'b01, 1'b1, 1'b0);
      step(2'b00, 2'b01, 1'b1, 1'b0);
      step(2'b00, 2'b00, 1'b1, 1'b0);
      chk("tp1_rel", 8'(HGRANT), 8'h00);

      // both masters requesting: alternate every MAX_HOLD cycles
      step(2'b00, 2'b00, 1'b1, 1'b1);
      for (int i = 0; i < 12; i++) begin
         step(2'b11, 2'b00, 1'b1, 1'b0);
         chk("tp2_alt", 8'(HGRANT), ((i / MH) % 2 == 0) ? 8'h01 : 8'h02);
      end

      // lock beats hold limit
      step(2'b00, 2'b00, 1'b1, 1'b1);
      for (int i = 0; i < 20; i++) step(2'b11, 2'b01, 1'b1, 1'b0);
      chk("tp3_locked", 8'(HGRANT), 8'h01);
      step(2'b10, 2'b00, 1'b1, 1'b0);
      chk("tp3_handover", 8'(HGRANT), 8'h02);

      // release while HREADY low, to IDLE and to another master
      step(2'b00, 2'b00, 1'b0, 1'b0);
      step(2'b00, 2'b00, 1'b0, 1'b0);
      step(2'b00, 2'b00, 1'b0, 1'b0);
      chk("tp4_held", 8'(HGRANT), 8'h02);
      step(2'b00, 2'b00, 1'b1, 1'b0);
      chk("tp4_idle", 8'(HGRANT), 8'h00);
      step(2'b01, 2'b00, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) step(2'b10, 2'b00, 1'b0, 1'b0);
      step(2'b10, 2'b00, 1'b1, 1'b0);
      chk("tp4_ho", 8'(HGRANT), 8'h02);

      // owner 1 drops as master 0 requests: no bubble
      step(2'b01, 2'b00, 1'b1, 1'b0);
      chk("tp5_nobubble", 8'(HGRANT), 8'h01);

      // reset mid locked ownership by master 1
      step(2'b10, 2'b10, 1'b1, 1'b0);
      step(2'b10, 2'b10, 1'b1, 1'b0);
      chk("tp6_lockset", 8'(HMASTLOCK), 8'h01);
      step(2'b10, 2'b10, 1'b1, 1'b1);
      chk("tp6_rst", 8'(HGRANT), 8'h00);
      step(2'b11, 2'b00, 1'b1, 1'b0);
      chk("tp6_first", 8'(HGRANT), 8'h01);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         br = N'($urandom);
         for (int b = 0; b < N; b++) lk[b] = ($urandom_range(0, 5) == 0);
         step(br, lk, ($urandom_range(0, 4) != 0), ($urandom_range(0, 60) == 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
